id_stage_pipe: RTL and testbench

//  Parametrised decode stage: decodes ARM-style data-processing, LDR/STR and B instructions.

---
 rtl/id_stage_pipe_if.sv | 50 +++++
 rtl/id_stage_pipe.sv | 192 +++++++++++++++++++
 tb/tb_id_stage_pipe.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_pipe_if.sv
// Bus between the IF/ID register, the decode stage and the EXE stage.
// The master drives the fetched instruction and write-back; the slave returns decode results.
interface id_stage_pipe_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned PC_W   = 32
);
  localparam int unsigned REG_AW = $clog2(NREG);

  logic              in_valid;
  logic [31:0]       Instruction;
  logic [PC_W-1:0]   pc_in;
  logic [3:0]        SR;
  logic              hazard;
  logic              stall;
  logic              flush;
  logic              wb_en;
  logic [REG_AW-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;

  logic [REG_AW-1:0] src1;
  logic [REG_AW-1:0] src2;
  logic              Two_src;
  logic              valid_out;
  logic              WB_EN;
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic              B;
  logic              S;
  logic [3:0]        EXE_CMD;
  logic [DATA_W-1:0] Val_Rn;
  logic [DATA_W-1:0] Val_Rm;
  logic              imm;
  logic [11:0]       Shift_operand;
  logic [23:0]       Signed_imm_24;
  logic [REG_AW-1:0] Dest;
  logic [PC_W-1:0]   pc_out;

  modport master (
    output in_valid, Instruction, pc_in, SR, hazard, stall, flush, wb_en, wb_dest, wb_data,
    input  src1, src2, Two_src, valid_out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
           Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, pc_out
  );

  modport slave (
    input  in_valid, Instruction, pc_in, SR, hazard, stall, flush, wb_en, wb_dest, wb_data,
    output src1, src2, Two_src, valid_out, WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD,
           Val_Rn, Val_Rm, imm, Shift_operand, Signed_imm_24, Dest, pc_out
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Decode stage: ARM-style decode, condition check, register file with write-back bypass,
// and the ID/EXE pipeline register with flush/stall and a valid bit.
module id_stage_pipe #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned PC_W   = 32,
  parameter bit          BYPASS = 1'b1
) (
  input logic            clk,
  input logic            rst,
  id_stage_pipe_if.slave bus
);
  localparam int unsigned REG_AW = $clog2(NREG);

  logic [3:0] w_cond;
  logic [1:0] w_mode;
  logic       w_i;
  logic [3:0] w_opc;
  logic       w_s_bit;
  logic       w_n, w_z, w_c, w_v;

  assign w_cond  = bus.Instruction[31:28];
  assign w_mode  = bus.Instruction[27:26];
  assign w_i     = bus.Instruction[25];
  assign w_opc   = bus.Instruction[24:21];
  assign w_s_bit = bus.Instruction[20];
  assign {w_n, w_z, w_c, w_v} = bus.SR;

  logic w_cond_ok;
  always_comb begin
    w_cond_ok = 1'b0;
    unique case (w_cond)
      4'b0000: w_cond_ok = w_z;
      4'b0001: w_cond_ok = ~w_z;
      4'b0010: w_cond_ok = w_c;
      4'b0011: w_cond_ok = ~w_c;
      4'b0100: w_cond_ok = w_n;
      4'b0101: w_cond_ok = ~w_n;
      4'b0110: w_cond_ok = w_v;
      4'b0111: w_cond_ok = ~w_v;
      4'b1000: w_cond_ok = w_c & ~w_z;
      4'b1001: w_cond_ok = ~w_c | w_z;
      4'b1010: w_cond_ok = (w_n == w_v);
      4'b1011: w_cond_ok = (w_n != w_v);
      4'b1100: w_cond_ok = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ok = w_z | (w_n != w_v);
      4'b1110: w_cond_ok = 1'b1;
      4'b1111: w_cond_ok = 1'b0;
    endcase
  end

  logic       w_wb_en, w_mem_r, w_mem_w, w_b, w_s;
  logic [3:0] w_cmd;
  always_comb begin
    w_wb_en = 1'b0;
    w_mem_r = 1'b0;
    w_mem_w = 1'b0;
    w_b     = 1'b0;
    w_s     = 1'b0;
    w_cmd   = 4'b0000;
    case (w_mode)
      2'b00: begin
        w_wb_en = 1'b1;
        w_s     = w_s_bit;
        case (w_opc)
          4'b1101: w_cmd = 4'b0001;
          4'b1111: w_cmd = 4'b1001;
          4'b0100: w_cmd = 4'b0010;
          4'b0101: w_cmd = 4'b0011;
          4'b0010: w_cmd = 4'b0100;
          4'b0110: w_cmd = 4'b0101;
          4'b0000: w_cmd = 4'b0110;
          4'b1100: w_cmd = 4'b0111;
          4'b0001: w_cmd = 4'b1000;
          4'b1010: begin w_cmd = 4'b0100; w_wb_en = 1'b0; end
          4'b1000: begin w_cmd = 4'b0110; w_wb_en = 1'b0; end
          default: begin w_wb_en = 1'b0; w_s = 1'b0; end
        endcase
      end
      2'b01: begin
        // Memory ops only decode with opc 0100; the S bit selects load versus store.
        if (w_opc == 4'b0100) begin
          w_cmd   = 4'b0010;
          w_wb_en = w_s_bit;
          w_mem_r = w_s_bit;
          w_mem_w = ~w_s_bit;
        end
      end
      2'b10:   w_b = 1'b1;
      default: ;
    endcase
  end

  logic [REG_AW-1:0] w_rn, w_rd, w_rm, w_src2;
  assign w_rn   = bus.Instruction[16 +: REG_AW];
  assign w_rd   = bus.Instruction[12 +: REG_AW];
  assign w_rm   = bus.Instruction[0 +: REG_AW];
  assign w_src2 = w_mem_w ? w_rd : w_rm;

  assign bus.src1    = w_rn;
  assign bus.src2    = w_src2;
  assign bus.Two_src = ~w_i | w_mem_w;

  logic [DATA_W-1:0] r_rf [NREG];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(NREG); i++) r_rf[i] <= '0;
    end else if (bus.wb_en) begin
      r_rf[bus.wb_dest] <= bus.wb_data;
    end
  end

  logic [DATA_W-1:0] w_val_rn, w_val_rm;
  generate
    if (BYPASS) begin : g_bypass
      assign w_val_rn = (bus.wb_en && bus.wb_dest == w_rn) ? bus.wb_data : r_rf[w_rn];
      assign w_val_rm = (bus.wb_en && bus.wb_dest == w_src2) ? bus.wb_data : r_rf[w_src2];
    end else begin : g_no_bypass
      assign w_val_rn = r_rf[w_rn];
      assign w_val_rm = r_rf[w_src2];
    end
  endgenerate

  logic w_bubble;
  assign w_bubble = ~bus.in_valid | bus.hazard | ~w_cond_ok;

  logic              r_valid, r_wb_en, r_mem_r, r_mem_w, r_b, r_s, r_imm;
  logic [3:0]        r_cmd;
  logic [DATA_W-1:0] r_val_rn, r_val_rm;
  logic [11:0]       r_shift;
  logic [23:0]       r_simm;
  logic [REG_AW-1:0] r_dest;
  logic [PC_W-1:0]   r_pc;

  // Flush only kills the controls and valid; data fields are don't-care and simply hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_wb_en  <= 1'b0;
      r_mem_r  <= 1'b0;
      r_mem_w  <= 1'b0;
      r_b      <= 1'b0;
      r_s      <= 1'b0;
      r_cmd    <= '0;
      r_imm    <= 1'b0;
      r_val_rn <= '0;
      r_val_rm <= '0;
      r_shift  <= '0;
      r_simm   <= '0;
      r_dest   <= '0;
      r_pc     <= '0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
      r_wb_en <= 1'b0;
      r_mem_r <= 1'b0;
      r_mem_w <= 1'b0;
      r_b     <= 1'b0;
      r_s     <= 1'b0;
      r_cmd   <= '0;
    end else if (!bus.stall) begin
      r_valid  <= ~w_bubble;
      r_wb_en  <= w_wb_en & ~w_bubble;
      r_mem_r  <= w_mem_r & ~w_bubble;
      r_mem_w  <= w_mem_w & ~w_bubble;
      r_b      <= w_b & ~w_bubble;
      r_s      <= w_s & ~w_bubble;
      r_cmd    <= w_bubble ? 4'b0000 : w_cmd;
      r_imm    <= w_i;
      r_val_rn <= w_val_rn;
      r_val_rm <= w_val_rm;
      r_shift  <= bus.Instruction[11:0];
      r_simm   <= bus.Instruction[23:0];
      r_dest   <= w_rd;
      r_pc     <= bus.pc_in;
    end
  end

  assign bus.valid_out     = r_valid;
  assign bus.WB_EN         = r_wb_en;
  assign bus.MEM_R_EN      = r_mem_r;
  assign bus.MEM_W_EN      = r_mem_w;
  assign bus.B             = r_b;
  assign bus.S             = r_s;
  assign bus.EXE_CMD       = r_cmd;
  assign bus.imm           = r_imm;
  assign bus.Val_Rn        = r_val_rn;
  assign bus.Val_Rm        = r_val_rm;
  assign bus.Shift_operand = r_shift;
  assign bus.Signed_imm_24 = r_simm;
  assign bus.Dest          = r_dest;
  assign bus.pc_out        = r_pc;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus random traffic against a behavioural model,
// with one instance bypassing write-back and one reading the old register value.
module tb_id_stage_pipe;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 16;
  localparam int unsigned PC_W   = 32;

  typedef struct packed {
    logic        valid;
    logic        wb;
    logic        mr;
    logic        mw;
    logic        b;
    logic        s;
    logic [3:0]  cmd;
    logic        imm;
    logic [11:0] shop;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [31:0] pc;
    logic [31:0] vrn;
    logic [31:0] vrm;
  } out_t;

  // ALU command per data-processing opcode; -1 marks an undefined opcode.
  localparam int DP_CMD [16] = '{6, 8, 4, -1, 2, 3, 5, -1, 6, -1, 4, -1, 7, 1, -1, 9};

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) bus ();
  id_stage_pipe_if #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W)) bus0 ();

  id_stage_pipe #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  id_stage_pipe #(.DATA_W(DATA_W), .NREG(NREG), .PC_W(PC_W), .BYPASS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  assign bus0.in_valid    = bus.in_valid;
  assign bus0.Instruction = bus.Instruction;
  assign bus0.pc_in       = bus.pc_in;
  assign bus0.SR          = bus.SR;
  assign bus0.hazard      = bus.hazard;
  assign bus0.stall       = bus.stall;
  assign bus0.flush       = bus.flush;
  assign bus0.wb_en       = bus.wb_en;
  assign bus0.wb_dest     = bus.wb_dest;
  assign bus0.wb_data     = bus.wb_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_rf [16];
  out_t        e1;
  out_t        e0;

  function automatic out_t obs1();
    out_t o;
    o = {bus.valid_out, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.B, bus.S, bus.EXE_CMD, bus.imm,
         bus.Shift_operand, bus.Signed_imm_24, bus.Dest, bus.pc_out, bus.Val_Rn, bus.Val_Rm};
    return o;
  endfunction

  function automatic out_t obs0();
    out_t o;
    o = {bus0.valid_out, bus0.WB_EN, bus0.MEM_R_EN, bus0.MEM_W_EN, bus0.B, bus0.S, bus0.EXE_CMD,
         bus0.imm, bus0.Shift_operand, bus0.Signed_imm_24, bus0.Dest, bus0.pc_out, bus0.Val_Rn,
         bus0.Val_Rm};
    return o;
  endfunction

  // ARM rule: odd codes negate the even code below them; 1110 is always, so 1111 is never.
  function automatic logic m_cond(logic [3:0] c, logic [3:0] sr);
    logic n, z, cf, v, base;
    {n, z, cf, v} = sr;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic out_t m_ctrl(logic [31:0] ins);
    out_t       o;
    logic [1:0] mode;
    logic [3:0] opc;
    int         cmd;
    o    = '0;
    mode = ins[27:26];
    opc  = ins[24:21];
    if (mode == 2'b00) begin
      cmd = DP_CMD[opc];
      if (cmd >= 0) begin
        o.cmd = 4'(cmd);
        o.s   = ins[20];
        o.wb  = !(opc == 4'b1000 || opc == 4'b1010);
      end
    end else if (mode == 2'b01 && opc == 4'b0100) begin
      o.cmd = 4'd2;
      if (ins[20]) begin o.wb = 1'b1; o.mr = 1'b1; end
      else o.mw = 1'b1;
    end else if (mode == 2'b10) begin
      o.b = 1'b1;
    end
    return o;
  endfunction

  function automatic out_t kill(out_t o);
    out_t k;
    k       = o;
    k.valid = 1'b0;
    k.wb    = 1'b0;
    k.mr    = 1'b0;
    k.mw    = 1'b0;
    k.b     = 1'b0;
    k.s     = 1'b0;
    k.cmd   = 4'd0;
    return k;
  endfunction

  function automatic logic [31:0] rd_val(logic [3:0] a, bit byp);
    return (byp && bus.wb_en && bus.wb_dest == a) ? bus.wb_data : m_rf[a];
  endfunction

  // Next expected ID/EXE contents for both instances, then the register-file write.
  task automatic model_edge();
    out_t        c, n;
    logic [31:0] ins;
    logic        bub;
    logic [3:0]  s2;
    ins = bus.Instruction;
    c   = m_ctrl(ins);
    s2  = c.mw ? ins[15:12] : ins[3:0];
    bub = !bus.in_valid || bus.hazard || !m_cond(ins[31:28], bus.SR);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? e1 : e0;
      if (bus.flush) begin
        n = kill(n);
      end else if (!bus.stall) begin
        n       = bub ? kill(c) : c;
        n.valid = !bub;
        n.imm   = ins[25];
        n.shop  = ins[11:0];
        n.simm  = ins[23:0];
        n.dest  = ins[15:12];
        n.pc    = bus.pc_in;
        n.vrn   = rd_val(ins[19:16], k == 0);
        n.vrm   = rd_val(s2, k == 0);
      end
      if (k == 0) e1 = n;
      else e0 = n;
    end
    if (bus.wb_en) m_rf[bus.wb_dest] = bus.wb_data;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid    = 1'b0;
    bus.Instruction = 32'h0;
    bus.pc_in       = 32'h0;
    bus.SR          = 4'h0;
    bus.hazard      = 1'b0;
    bus.stall       = 1'b0;
    bus.flush       = 1'b0;
    bus.wb_en       = 1'b0;
    bus.wb_dest     = 4'h0;
    bus.wb_data     = 32'h0;
  endtask

  task automatic model_clear();
    e1 = '0;
    e0 = '0;
    for (int i = 0; i < 16; i++) m_rf[i] = 32'h0;
  endtask

  task automatic test_reset();
    logic [31:0] ins;
    logic [3:0]  a;
    rst             = 1'b0;
    bus.in_valid    = 1'b1;
    bus.Instruction = $urandom;
    bus.pc_in       = $urandom;
    bus.SR          = 4'($urandom);
    bus.hazard      = 1'($urandom);
    bus.stall       = 1'($urandom);
    bus.flush       = 1'($urandom);
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 4'($urandom);
    bus.wb_data     = $urandom;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs1() !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", obs1());
    end
    checks++;
    if (obs0() !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_outputs_nobyp: got %h want 0", obs0());
    end
    set_idle();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a               = 4'(i);
      ins             = {4'hE, 2'b00, 1'b0, 4'b1101, 1'b0, a, 4'h0, 8'h00, a};
      bus.Instruction = ins;
      bus.in_valid    = 1'b1;
      tick();
      checks++;
      if (obs1() !== e1 || bus.Val_Rn !== 32'h0 || bus.Val_Rm !== 32'h0) begin
        errors++;
        $display("FAIL reset_rf_read r%0d: got %h want %h", i, obs1(), e1);
      end
    end
  endtask

  task automatic test_add();
    set_idle();
    bus.wb_en   = 1'b1;
    bus.wb_dest = 4'd3;
    bus.wb_data = 32'h1234;
    tick();
    bus.wb_en       = 1'b0;
    bus.Instruction = 32'hE0831003;
    bus.in_valid    = 1'b1;
    bus.pc_in       = 32'h100;
    tick();
    checks++;
    if ({bus.EXE_CMD, bus.WB_EN, bus.valid_out, bus.Dest} !== {4'b0010, 1'b1, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL add_ctrl: got cmd=%b wb=%b v=%b dest=%0d want cmd=0010 wb=1 v=1 dest=1",
               bus.EXE_CMD, bus.WB_EN, bus.valid_out, bus.Dest);
    end
    checks++;
    if (bus.Val_Rn !== 32'h1234 || bus.Val_Rm !== 32'h1234) begin
      errors++;
      $display("FAIL add_operands: got rn=%h rm=%h want 1234/1234", bus.Val_Rn, bus.Val_Rm);
    end
    checks++;
    if (obs1() !== e1) begin
      errors++;
      $display("FAIL add_model: got %h want %h", obs1(), e1);
    end
  endtask

  task automatic test_bypass();
    bus.Instruction = 32'hE0831003;
    bus.in_valid    = 1'b1;
    bus.wb_en       = 1'b1;
    bus.wb_dest     = 4'd3;
    bus.wb_data     = 32'hAA;
    tick();
    checks++;
    if (bus.Val_Rn !== 32'hAA) begin
      errors++;
      $display("FAIL bypass_on: got %h want 000000aa", bus.Val_Rn);
    end
    checks++;
    if (bus0.Val_Rn !== 32'h1234) begin
      errors++;
      $display("FAIL bypass_off_old: got %h want 00001234", bus0.Val_Rn);
    end
    bus.wb_en = 1'b0;
    tick();
    checks++;
    if (bus0.Val_Rn !== 32'hAA || obs0() !== e0) begin
      errors++;
      $display("FAIL bypass_off_next: got %h want %h", obs0(), e0);
    end
  endtask

  task automatic test_cond();
    set_idle();
    bus.Instruction = 32'h03A01005;
    bus.in_valid    = 1'b1;
    bus.SR          = 4'b0000;
    tick();
    checks++;
    if ({bus.valid_out, bus.WB_EN, bus.MEM_R_EN, bus.MEM_W_EN, bus.B, bus.S, bus.EXE_CMD} !== 10'b0)
    begin
      errors++;
      $display("FAIL cond_fail: got v=%b wb=%b cmd=%b want all 0",
               bus.valid_out, bus.WB_EN, bus.EXE_CMD);
    end
    bus.SR = 4'b0100;
    tick();
    checks++;
    if ({bus.valid_out, bus.WB_EN, bus.EXE_CMD} !== {1'b1, 1'b1, 4'b0001} || obs1() !== e1) begin
      errors++;
      $display("FAIL cond_pass: got %h want %h", obs1(), e1);
    end
  endtask

  task automatic test_stall();
    out_t saved;
    set_idle();
    bus.Instruction = 32'hE0831003;
    bus.in_valid    = 1'b1;
    bus.pc_in       = 32'h200;
    tick();
    saved = e1;
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.Instruction = $urandom;
      bus.pc_in       = $urandom;
      bus.SR          = 4'($urandom);
      tick();
      checks++;
      if (obs1() !== saved) begin
        errors++;
        $display("FAIL stall_hold cycle %0d: got %h want %h", i, obs1(), saved);
      end
    end
    bus.flush = 1'b1;
    tick();
    checks++;
    if (bus.valid_out !== 1'b0 || obs1() !== e1) begin
      errors++;
      $display("FAIL stall_flush: got %h want %h", obs1(), e1);
    end
    set_idle();
  endtask

  task automatic test_store();
    set_idle();
    // The opc field must be 0100 for the memory decode; P/U-style encodings are undefined here.
    bus.Instruction = 32'hE4842008;
    bus.in_valid    = 1'b1;
    #1;
    checks++;
    if ({bus.src1, bus.src2, bus.Two_src} !== {4'd4, 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL store_comb: got src1=%0d src2=%0d two=%b want 4 2 1",
               bus.src1, bus.src2, bus.Two_src);
    end
    tick();
    checks++;
    if ({bus.valid_out, bus.MEM_W_EN, bus.WB_EN, bus.MEM_R_EN, bus.S, bus.EXE_CMD}
        !== {5'b11000, 4'b0010} || obs1() !== e1) begin
      errors++;
      $display("FAIL store_ctrl: got %h want %h", obs1(), e1);
    end
    bus.hazard = 1'b1;
    tick();
    checks++;
    if ({bus.valid_out, bus.MEM_W_EN, bus.EXE_CMD} !== 6'b0 || obs1() !== e1) begin
      errors++;
      $display("FAIL store_hazard: got %h want %h", obs1(), e1);
    end
    set_idle();
  endtask

  task automatic test_reset_mid();
    set_idle();
    bus.Instruction = 32'hE0831003;
    bus.in_valid    = 1'b1;
    tick();
    bus.stall = 1'b1;
    #3;
    rst = 1'b0;
    #1;
    model_clear();
    checks++;
    if (obs1() !== out_t'(0) || obs0() !== out_t'(0)) begin
      errors++;
      $display("FAIL reset_mid_stall: got %h want 0", obs1());
    end
    #1;
    rst = 1'b1;
    bus.stall = 1'b0;
    tick();
    checks++;
    if (obs1() !== e1 || bus.Val_Rn !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_rf: got %h want %h", obs1(), e1);
    end
  endtask

  task automatic test_random();
    logic [31:0] ins;
    out_t        c;
    logic [3:0]  s2;
    for (int i = 0; i < 400; i++) begin
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[31:28] = 4'hE;
      if (ins[27:26] == 2'b01 && $urandom_range(0, 1) == 1) ins[24:21] = 4'b0100;
      bus.Instruction = ins;
      bus.in_valid    = ($urandom_range(0, 9) != 0);
      bus.pc_in       = $urandom;
      bus.SR          = 4'($urandom);
      bus.hazard      = ($urandom_range(0, 9) == 0);
      bus.stall       = ($urandom_range(0, 6) == 0);
      bus.flush       = ($urandom_range(0, 9) == 0);
      bus.wb_en       = 1'($urandom);
      bus.wb_dest     = 4'($urandom);
      bus.wb_data     = $urandom;
      #1;
      c  = m_ctrl(ins);
      s2 = c.mw ? ins[15:12] : ins[3:0];
      checks++;
      if ({bus.src1, bus.src2, bus.Two_src} !== {ins[19:16], s2, (!ins[25] || c.mw)}) begin
        errors++;
        $display("FAIL rand_comb %0d: got %h want %h", i, {bus.src1, bus.src2, bus.Two_src},
                 {ins[19:16], s2, (!ins[25] || c.mw)});
      end
      tick();
      checks++;
      if (obs1() !== e1) begin
        errors++;
        $display("FAIL rand_byp %0d: got %h want %h", i, obs1(), e1);
      end
      checks++;
      if (obs0() !== e0) begin
        errors++;
        $display("FAIL rand_nobyp %0d: got %h want %h", i, obs0(), e0);
      end
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_add();
    test_bypass();
    test_cond();
    test_stall();
    test_store();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
